// File: rtl/instruction_fetch_decode_if.sv
// rtl/instruction_fetch_decode_if.sv - fetch/decode bus between instruction memory, control FSM and front end
interface instruction_fetch_decode_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               nextInstruction;
    logic               enablePC;
    logic               enableJUMP;
    logic               enableCMPJUMP;
    logic               cmp_true;
    logic               alu;
    logic               ld;
    logic               st;
    logic               jump;
    logic               cmpJump;
    logic               cmpJumpEnable;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc;
    logic               illegal_op;

    modport master (
        output imem_addr, alu, ld, st, jump, cmpJump, cmpJumpEnable, ir, pc, illegal_op,
        input  imem_data, nextInstruction, enablePC, enableJUMP, enableCMPJUMP, cmp_true
    );

    modport slave (
        input  imem_addr, alu, ld, st, jump, cmpJump, cmpJumpEnable, ir, pc, illegal_op,
        output imem_data, nextInstruction, enablePC, enableJUMP, enableCMPJUMP, cmp_true
    );
endinterface

// File: rtl/instruction_fetch_decode.sv
// rtl/instruction_fetch_decode.sv - PC, instruction register and opcode class decode for the control FSM
module instruction_fetch_decode #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input logic                        clk,
    input logic                        reset,
    instruction_fetch_decode_if.master bus
);
    typedef enum logic [1:0] {FETCH, LATCH, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  target;
    logic [INSTR_W-1:0] ir_q;
    logic [3:0]         opcode;
    logic               is_illegal;

    logic alu_s, ld_s, st_s, jump_s, cmpjump_s, illegal_s;

    assign opcode     = ir_q[INSTR_W-1 -: 4];
    assign target     = ir_q[ADDR_W-1:0];
    assign pc_inc     = pc_q + ADDR_W'(1);
    assign is_illegal = (opcode[3:2] == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc_q  <= '0;
            ir_q  <= '0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            if (state == LATCH) begin
                ir_q <= bus.imem_data;
            end
        end
    end

    // An illegal opcode retires itself after a single HOLD cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:   state_next = LATCH;
            LATCH:   state_next = HOLD;
            HOLD:    state_next = (is_illegal || bus.nextInstruction) ? FETCH : HOLD;
            default: state_next = FETCH;
        endcase
    end

    // PC moves only in HOLD; illegal opcodes always step over themselves.
    always_comb begin
        pc_next = pc_q;
        if (state == HOLD) begin
            if (is_illegal) begin
                pc_next = pc_inc;
            end else if (bus.enableJUMP) begin
                pc_next = target;
            end else if (bus.enableCMPJUMP && bus.cmp_true) begin
                pc_next = target;
            end else if (bus.enablePC || bus.enableCMPJUMP) begin
                pc_next = pc_inc;
            end
        end
    end

    always_comb begin
        alu_s     = 1'b0;
        ld_s      = 1'b0;
        st_s      = 1'b0;
        jump_s    = 1'b0;
        cmpjump_s = 1'b0;
        illegal_s = 1'b0;
        if (state == HOLD) begin
            if (!opcode[3]) begin
                alu_s = 1'b1;
            end else begin
                unique case (opcode[2:0])
                    3'b000:  ld_s      = 1'b1;
                    3'b001:  st_s      = 1'b1;
                    3'b010:  jump_s    = 1'b1;
                    3'b011:  cmpjump_s = 1'b1;
                    default: illegal_s = 1'b1;
                endcase
            end
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.pc            = pc_q;
    assign bus.ir            = ir_q;
    assign bus.alu           = alu_s;
    assign bus.ld            = ld_s;
    assign bus.st            = st_s;
    assign bus.jump          = jump_s;
    assign bus.cmpJump       = cmpjump_s;
    assign bus.cmpJumpEnable = cmpjump_s & bus.cmp_true;
    assign bus.illegal_op    = illegal_s;
endmodule

// File: tb/tb_instruction_fetch_decode.sv
// tb/tb_instruction_fetch_decode.sv - directed and randomized bench for instruction_fetch_decode
module tb_instruction_fetch_decode;
    logic clk;
    logic reset;

    instruction_fetch_decode_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instruction_fetch_decode #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [15:0] mem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    int          n_checks;
    int          n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected {alu, ld, st, jump, cmpJump, illegal_op} for a word sitting in HOLD.
    function automatic logic [5:0] exp_dec(input logic [15:0] w);
        int op;
        op = int'(w >> 12);
        return {op < 8, op == 8, op == 9, op == 10, op == 11, op >= 12};
    endfunction

    function automatic logic [31:0] strobes();
        return {26'd0, bus.alu, bus.ld, bus.st, bus.jump, bus.cmpJump, bus.illegal_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.nextInstruction = 1'b0;
        bus.enablePC        = 1'b0;
        bus.enableJUMP      = 1'b0;
        bus.enableCMPJUMP   = 1'b0;
        bus.cmp_true        = 1'b0;
    endtask

    task automatic noise(input bit on);
        if (on) begin
            bus.nextInstruction = 1'($urandom);
            bus.enablePC        = 1'($urandom);
            bus.enableJUMP      = 1'($urandom);
            bus.enableCMPJUMP   = 1'($urandom);
            bus.cmp_true        = 1'($urandom);
        end
    endtask

    // Entered just after the edge that put the DUT into FETCH at m_pc.
    task automatic fetch_to_hold(input bit noisy);
        chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("fetch_strobes", strobes(), 32'd0);
        noise(noisy);
        tick();
        clear_inputs();
        chk("latch_pc", 32'(bus.pc), 32'(m_pc));
        chk("latch_strobes", strobes(), 32'd0);
        noise(noisy);
        tick();
        clear_inputs();
        m_ir = mem[m_pc];
        chk("hold_ir", 32'(bus.ir), 32'(m_ir));
        chk("hold_pc", 32'(bus.pc), 32'(m_pc));
    endtask

    task automatic hold_step(input bit ni, input bit epc, input bit ej, input bit ecj,
                             input bit cmp, output bit left);
        logic [5:0] d;
        logic [7:0] tgt;
        d   = exp_dec(m_ir);
        tgt = m_ir[7:0];
        bus.nextInstruction = ni;
        bus.enablePC        = epc;
        bus.enableJUMP      = ej;
        bus.enableCMPJUMP   = ecj;
        bus.cmp_true        = cmp;
        #1;
        chk("hold_strobes", strobes(), 32'(d));
        chk("cmp_jump_enable", 32'(bus.cmpJumpEnable), 32'(d[1] & cmp));
        tick();
        clear_inputs();
        if (d[0])            m_pc = m_pc + 8'd1;
        else if (ej)         m_pc = tgt;
        else if (ecj && cmp) m_pc = tgt;
        else if (epc || ecj) m_pc = m_pc + 8'd1;
        left = ni | d[0];
        chk("next_pc", 32'(bus.pc), 32'(m_pc));
        if (left) begin
            chk("retired_strobes", strobes(), 32'd0);
            chk("retired_addr", 32'(bus.imem_addr), 32'(m_pc));
        end
    endtask

    initial begin
        bit left;
        bit ni, epc, ej, ecj, cmp;
        int stalls;
        int sel;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        clear_inputs();
        reset = 1'b1;
        m_pc  = 8'd0;
        m_ir  = 16'd0;

        tick();
        tick();
        chk("reset_pc", 32'(bus.pc), 32'd0);
        chk("reset_addr", 32'(bus.imem_addr), 32'd0);
        chk("reset_ir", 32'(bus.ir), 32'd0);
        chk("reset_strobes", strobes(), 32'd0);
        chk("reset_cje", 32'(bus.cmpJumpEnable), 32'd0);

        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'hA03C;
        mem[8'h3C] = 16'hB050;
        mem[8'h3D] = 16'hB050;
        mem[8'h50] = 16'hA0FF;
        mem[8'hFF] = 16'h8000;
        reset = 1'b0;

        fetch_to_hold(1'b0);
        for (int i = 0; i < 5; i++) hold_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, left);
        hold_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, left);
        chk("alu_advance_pc", 32'(bus.pc), 32'h01);

        fetch_to_hold(1'b0);
        hold_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, left);
        chk("jump_pc", 32'(bus.pc), 32'h3C);

        fetch_to_hold(1'b0);
        hold_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, left);
        chk("cmpjump_not_taken", 32'(bus.pc), 32'h3D);
        fetch_to_hold(1'b0);
        hold_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, left);
        chk("cmpjump_taken", 32'(bus.pc), 32'h50);

        fetch_to_hold(1'b0);
        hold_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, left);
        fetch_to_hold(1'b0);
        hold_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, left);
        chk("wrap_pc", 32'(bus.pc), 32'h00);

        mem[8'h00] = 16'hC000;
        mem[8'h01] = 16'h9000;
        fetch_to_hold(1'b0);
        hold_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, left);
        chk("illegal_pc", 32'(bus.pc), 32'h01);
        chk("illegal_once", 32'(bus.illegal_op), 32'd0);

        fetch_to_hold(1'b0);
        chk("st_strobe", strobes(), 32'b001000);
        reset        = 1'b1;
        bus.enablePC = 1'b1;
        tick();
        clear_inputs();
        chk("midhold_reset_strobes", strobes(), 32'd0);
        chk("midhold_reset_pc", 32'(bus.pc), 32'd0);
        chk("midhold_reset_ir", 32'(bus.ir), 32'd0);
        reset = 1'b0;
        m_pc  = 8'd0;

        for (int n = 0; n < 60; n++) begin
            mem[m_pc] = 16'($urandom);
            fetch_to_hold(1'b1);
            stalls = int'($urandom_range(0, 2));
            left   = 1'b0;
            for (int k = 0; k <= stalls && !left; k++) begin
                sel = int'($urandom_range(0, 5));
                ni  = (k == stalls);
                epc = (sel == 1) || (sel == 4) || (sel == 5);
                ej  = (sel == 2) || (sel == 5);
                ecj = (sel == 3) || (sel == 4);
                cmp = 1'($urandom);
                hold_step(ni, epc, ej, ecj, cmp, left);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
